step_cmd_sequencer: RTL and testbench
=====================================

Name: step_cmd_sequencer

Overview:
- Command front-end sitting directly upstream of the 8-bit up/down step counter; drives its preload, up_dn, delta and pl_data inputs.
- Accepts step commands over a valid/ready handshake and buffers them in a small FIFO.
- Expands each command into one or more single-cycle counter operations.
- Provides abort/flush, busy, and per-command done signalling.

Parameters:
- FIFO_DEPTH, 4, command FIFO entries; power of two, >= 2.
- REP_W, 4, width of the repeat field; a command issues repeat+1 operations.

Ports:
- clk  input  1  rising-edge clock.
- reset_n  input  1  asynchronous active-low reset.
- cmd_valid  input  1  command present.
- cmd_ready  output  1  sequencer accepts the command this cycle.
- cmd_op  input  2  operation: 0 PRELOAD, 1 UP, 2 DOWN, 3 HOLD.
- cmd_arg  input  8  PRELOAD value; UP/DOWN use arg[3:0] as the step; ignored for HOLD.
- cmd_rep  input  REP_W  repeat count minus one; ignored for PRELOAD.
- abort  input  1  flush the FIFO and stop the current command.
- preload  output  1  to counter preload.
- up_dn  output  1  to counter up_dn.
- delta  output  4  to counter delta.
- pl_data  output  8  to counter pl_data.
- busy  output  1  a command is executing or the FIFO is non-empty.
- cmd_done  output  1  one-cycle pulse on the last operation of each command.
- fifo_level  output  clog2(FIFO_DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset (reset_n low, asynchronous):
  - FIFO is emptied and the FSM enters IDLE.
  - preload, up_dn, delta, pl_data, busy, cmd_done and fifo_level all go to 0.
  - cmd_ready is 0 while reset_n is low.
- Idle drive:
  - Whenever no operation is issued: preload=0, up_dn=0, delta=0, pl_data=0.
  - The downstream counter therefore holds its value.
- Handshake:
  - cmd_ready = !full && !abort && reset_n.
  - A push occurs on an edge where cmd_valid && cmd_ready.
  - There is no pass-through when full; the push is refused even if a pop happens the same edge.
  - Push and pop on the same edge leave fifo_level unchanged.
- FSM states and transitions:
  - IDLE: if the FIFO is non-empty, pop the head, load the remaining count with rep (0 for PRELOAD), register the first operation onto the outputs, and go to ISSUE.
  - ISSUE: outputs hold the current operation for exactly one cycle.
    - If remaining > 0: decrement remaining and re-issue the same operation.
    - If remaining = 0 and the FIFO is non-empty: pop the next command in the same edge (no bubble).
    - If remaining = 0 and the FIFO is empty: go to IDLE with idle drive.
- Latency: a command pushed on edge N reaches the outputs after edge N+1 when the FSM was IDLE with an empty FIFO.
- Operation encoding (registered outputs):
  - PRELOAD: preload=1, pl_data=arg, delta=0, up_dn=0.
  - UP: preload=0, up_dn=1, delta=arg[3:0].
  - DOWN: preload=0, up_dn=0, delta=arg[3:0].
  - HOLD: preload=0, up_dn=0, delta=0.
- cmd_done is asserted in the same cycle as the last operation of a command. Consequences:
  - A PRELOAD command or any rep=0 command gives cmd_done in its single cycle.
  - Back-to-back single-op commands give a continuous cmd_done high, one cycle per command.
- busy = (state==ISSUE) || (fifo_level != 0).
- The sequencer does not track the counter value; saturation is the counter's responsibility.
- Abort:
  - On the edge abort is sampled high, the FIFO is flushed, the FSM goes to IDLE, and outputs go to idle drive.
  - cmd_done is not pulsed for the aborted command.
  - Abort overrides a simultaneous push (cmd_ready is low) and a simultaneous pop.
- Reset mid-command: identical to abort, but asynchronous.
- Full: fifo_level==FIFO_DEPTH forces cmd_ready=0.
- Empty: no pop occurs; outputs are held at idle drive once the last operation completes.
- Remaining counter: REP_W bits; rep=all-ones issues 2^REP_W operations with no wrap.

Test Plan:
- Reset, then push PRELOAD arg=0x40 -> one cycle with preload=1, pl_data=0x40, cmd_done=1; downstream qout=0x40; then idle drive; busy back to 0.
- Push UP arg=3 rep=4, then DOWN arg=2 rep=1 -> 5 cycles of up_dn=1/delta=3, then 2 cycles of up_dn=0/delta=2 with no gap; cmd_done high on cycles 5 and 7; qout from 0x40 ends at 0x4B.
- Hold cmd_valid with 6 commands while the FSM is busy -> cmd_ready drops when fifo_level=4; no command lost or duplicated; issue order matches push order.
- Assert abort during the 3rd cycle of UP rep=7 with 2 commands queued -> next edge: delta=0, fifo_level=0, busy=0, no cmd_done; a push attempted in the abort cycle is dropped.
- Assert reset_n low mid-HOLD rep=15 -> all outputs are 0 immediately without a clock edge; after release, the sequencer accepts a new command normally.
- Push UP arg=0xF rep=15 -> exactly 16 operation cycles; a single cmd_done on the 16th.

Source files
------------

// File: rtl/step_cmd_sequencer.sv
// Command front-end for the 8-bit up/down step counter: buffers step commands in a
// small FIFO and expands each one into repeat+1 single-cycle counter operations.
module step_cmd_sequencer #(
  parameter int FIFO_DEPTH = 4,
  parameter int REP_W      = 4
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          cmd_valid,
  output logic                          cmd_ready,
  input  logic [1:0]                    cmd_op,
  input  logic [7:0]                    cmd_arg,
  input  logic [REP_W-1:0]              cmd_rep,
  input  logic                          abort,
  output logic                          preload,
  output logic                          up_dn,
  output logic [3:0]                    delta,
  output logic [7:0]                    pl_data,
  output logic                          busy,
  output logic                          cmd_done,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int AW = $clog2(FIFO_DEPTH);

  localparam logic [1:0] OP_PRELOAD = 2'd0;
  localparam logic [1:0] OP_UP      = 2'd1;
  localparam logic [1:0] OP_DOWN    = 2'd2;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_ISSUE = 1'b1;

  logic [1:0]       op_mem  [FIFO_DEPTH];
  logic [7:0]       arg_mem [FIFO_DEPTH];
  logic [REP_W-1:0] rep_mem [FIFO_DEPTH];

  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;

  logic [0:0]       state;
  logic [REP_W-1:0] remaining;

  logic             full;
  logic             empty;
  logic             push;
  logic             pop;
  logic [1:0]       head_op;
  logic [7:0]       head_arg;
  logic [REP_W-1:0] head_rem;

  assign full      = (count == (AW+1)'(FIFO_DEPTH));
  assign empty     = (count == '0);
  assign cmd_ready = !full && !abort && reset_n;
  assign push      = cmd_valid && cmd_ready;

  // A pop happens from IDLE, or back-to-back on the last cycle of the current command.
  assign pop = !abort && !empty &&
               ((state == ST_IDLE) || ((state == ST_ISSUE) && (remaining == '0)));

  assign head_op  = op_mem[rd_ptr];
  assign head_arg = arg_mem[rd_ptr];
  assign head_rem = (head_op == OP_PRELOAD) ? '0 : rep_mem[rd_ptr];

  assign busy       = (state == ST_ISSUE) || (count != '0);
  assign fifo_level = count;

  always_ff @(posedge clk) begin
    if (push) begin
      op_mem[wr_ptr]  <= cmd_op;
      arg_mem[wr_ptr] <= cmd_arg;
      rep_mem[wr_ptr] <= cmd_rep;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (abort) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Outputs are registered with the operation; cmd_done marks the cycle where remaining hits zero.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_IDLE;
      remaining <= '0;
      preload   <= 1'b0;
      up_dn     <= 1'b0;
      delta     <= 4'd0;
      pl_data   <= 8'd0;
      cmd_done  <= 1'b0;
    end else if (abort) begin
      state     <= ST_IDLE;
      remaining <= '0;
      preload   <= 1'b0;
      up_dn     <= 1'b0;
      delta     <= 4'd0;
      pl_data   <= 8'd0;
      cmd_done  <= 1'b0;
    end else if (pop) begin
      state     <= ST_ISSUE;
      remaining <= head_rem;
      preload   <= (head_op == OP_PRELOAD);
      up_dn     <= (head_op == OP_UP);
      delta     <= ((head_op == OP_UP) || (head_op == OP_DOWN)) ? head_arg[3:0] : 4'd0;
      pl_data   <= (head_op == OP_PRELOAD) ? head_arg : 8'd0;
      cmd_done  <= (head_rem == '0);
    end else if ((state == ST_ISSUE) && (remaining != '0)) begin
      remaining <= remaining - 1'b1;
      cmd_done  <= (remaining == REP_W'(1));
    end else if (state == ST_ISSUE) begin
      state     <= ST_IDLE;
      preload   <= 1'b0;
      up_dn     <= 1'b0;
      delta     <= 4'd0;
      pl_data   <= 8'd0;
      cmd_done  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_step_cmd_sequencer.sv
// Directed bench for step_cmd_sequencer with a small downstream counter model (qout)
// that follows the sequencer outputs edge by edge.
module tb_step_cmd_sequencer;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic [7:0] cmd_arg;
  logic [3:0] cmd_rep;
  logic       abort;
  logic       preload;
  logic       up_dn;
  logic [3:0] delta;
  logic [7:0] pl_data;
  logic       busy;
  logic       cmd_done;
  logic [2:0] fifo_level;

  int         vectors = 0;
  int         miscompares = 0;
  logic [7:0] qout = 8'h00;

  step_cmd_sequencer #(.FIFO_DEPTH(4), .REP_W(4)) dut (
    .clk(clk), .reset_n(reset_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_arg(cmd_arg), .cmd_rep(cmd_rep), .abort(abort),
    .preload(preload), .up_dn(up_dn), .delta(delta), .pl_data(pl_data),
    .busy(busy), .cmd_done(cmd_done), .fifo_level(fifo_level)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic check_outs(input string tag, input logic pl, input logic ud,
                            input logic [3:0] d, input logic [7:0] pd, input logic done,
                            input logic bsy, input logic [2:0] lvl);
    check_output(tag, 32'({preload, up_dn, delta, pl_data, cmd_done, busy, fifo_level}),
                 32'({pl, ud, d, pd, done, bsy, lvl}));
  endtask

  task automatic apply_stimulus(input logic v, input logic [1:0] op, input logic [7:0] arg,
                                input logic [3:0] rep);
    cmd_valid = v;
    cmd_op    = op;
    cmd_arg   = arg;
    cmd_rep   = rep;
  endtask

  // Advance one clock; the counter model latches whatever was driven before the edge.
  task automatic tick();
    logic       p;
    logic       u;
    logic [3:0] d;
    logic [7:0] pd;
    p = preload; u = up_dn; d = delta; pd = pl_data;
    @(posedge clk);
    if (p)      qout = pd;
    else if (u) qout = qout + {4'b0, d};
    else        qout = qout - {4'b0, d};
    #1;
  endtask

  logic [1:0] c_op  [6];
  logic [7:0] c_arg [6];
  logic [3:0] c_rep [6];
  logic [4:0] exp_sig [6];
  int         idx;
  int         done_seen;
  int         ops_seen;
  int         done_at;
  logic       rdy;
  logic       vld;

  initial begin
    reset_n = 1'b1;
    abort   = 1'b0;
    apply_stimulus(1'b0, 2'd0, 8'h00, 4'd0);
    #1 reset_n = 1'b0;
    tick();
    tick();
    check_outs("reset_state", 1'b0, 1'b0, 4'h0, 8'h00, 1'b0, 1'b0, 3'd0);
    check_output("reset_ready", 32'(cmd_ready), 32'd0);
    reset_n = 1'b1;
    #1;
    check_output("ready_after_reset", 32'(cmd_ready), 32'd1);

    // Single PRELOAD: one cycle, then idle drive.
    apply_stimulus(1'b1, 2'd0, 8'h40, 4'd0);
    tick();
    apply_stimulus(1'b0, 2'd0, 8'h00, 4'd0);
    check_outs("pl_queued", 1'b0, 1'b0, 4'h0, 8'h00, 1'b0, 1'b1, 3'd1);
    tick();
    check_outs("pl_issue", 1'b1, 1'b0, 4'h0, 8'h40, 1'b1, 1'b1, 3'd0);
    tick();
    check_outs("pl_idle", 1'b0, 1'b0, 4'h0, 8'h00, 1'b0, 1'b0, 3'd0);
    check_output("qout_preload", 32'(qout), 32'h40);

    // UP 3 x5 followed immediately by DOWN 2 x2.
    apply_stimulus(1'b1, 2'd1, 8'h03, 4'd4);
    tick();
    apply_stimulus(1'b1, 2'd2, 8'h02, 4'd1);
    tick();
    apply_stimulus(1'b0, 2'd0, 8'h00, 4'd0);
    check_outs("up_c1", 1'b0, 1'b1, 4'h3, 8'h00, 1'b0, 1'b1, 3'd1);
    for (int i = 2; i <= 5; i++) begin
      tick();
      check_outs($sformatf("up_c%0d", i), 1'b0, 1'b1, 4'h3, 8'h00, 1'(i == 5), 1'b1, 3'd1);
    end
    tick();
    check_outs("down_c6", 1'b0, 1'b0, 4'h2, 8'h00, 1'b0, 1'b1, 3'd0);
    tick();
    check_outs("down_c7", 1'b0, 1'b0, 4'h2, 8'h00, 1'b1, 1'b1, 3'd0);
    tick();
    check_outs("updown_idle", 1'b0, 1'b0, 4'h0, 8'h00, 1'b0, 1'b0, 3'd0);
    check_output("qout_updown", 32'(qout), 32'h4B);

    // Six commands offered back to back; the FIFO fills and back-pressures.
    c_op[0] = 2'd1; c_arg[0] = 8'h01; c_rep[0] = 4'd7; exp_sig[0] = {1'b1, 4'h1};
    c_op[1] = 2'd1; c_arg[1] = 8'h02; c_rep[1] = 4'd0; exp_sig[1] = {1'b1, 4'h2};
    c_op[2] = 2'd2; c_arg[2] = 8'h03; c_rep[2] = 4'd0; exp_sig[2] = {1'b0, 4'h3};
    c_op[3] = 2'd1; c_arg[3] = 8'h04; c_rep[3] = 4'd0; exp_sig[3] = {1'b1, 4'h4};
    c_op[4] = 2'd2; c_arg[4] = 8'h05; c_rep[4] = 4'd0; exp_sig[4] = {1'b0, 4'h5};
    c_op[5] = 2'd1; c_arg[5] = 8'h06; c_rep[5] = 4'd0; exp_sig[5] = {1'b1, 4'h6};
    idx = 0; done_seen = 0; ops_seen = 0;
    apply_stimulus(1'b1, c_op[0], c_arg[0], c_rep[0]);
    for (int c = 0; c < 40; c++) begin
      rdy = cmd_ready;
      vld = cmd_valid;
      tick();
      if (vld && rdy) idx++;
      if (c == 4) begin
        check_output("full_level", 32'(fifo_level), 32'd4);
        check_output("full_ready", 32'(cmd_ready), 32'd0);
      end
      if (idx < 6) apply_stimulus(1'b1, c_op[idx], c_arg[idx], c_rep[idx]);
      else         apply_stimulus(1'b0, 2'd0, 8'h00, 4'd0);
      if (delta != 4'h0) ops_seen++;
      if (cmd_done) begin
        if (done_seen < 6)
          check_output($sformatf("order_%0d", done_seen), 32'({up_dn, delta}),
                       32'(exp_sig[done_seen]));
        done_seen++;
      end
    end
    check_output("burst_pushes", 32'(idx), 32'd6);
    check_output("burst_dones", 32'(done_seen), 32'd6);
    check_output("burst_ops", 32'(ops_seen), 32'd13);
    check_output("burst_idle", 32'({busy, fifo_level}), 32'd0);

    // Abort on the 3rd cycle of UP x8 with two commands queued.
    apply_stimulus(1'b1, 2'd1, 8'h05, 4'd7);
    tick();
    apply_stimulus(1'b1, 2'd3, 8'h00, 4'd0);
    tick();
    check_outs("ab_c1", 1'b0, 1'b1, 4'h5, 8'h00, 1'b0, 1'b1, 3'd1);
    apply_stimulus(1'b1, 2'd1, 8'h01, 4'd0);
    tick();
    apply_stimulus(1'b0, 2'd0, 8'h00, 4'd0);
    tick();
    check_outs("ab_c3", 1'b0, 1'b1, 4'h5, 8'h00, 1'b0, 1'b1, 3'd2);
    abort = 1'b1;
    apply_stimulus(1'b1, 2'd2, 8'h07, 4'd0);
    #1;
    check_output("ab_ready", 32'(cmd_ready), 32'd0);
    tick();
    abort = 1'b0;
    apply_stimulus(1'b0, 2'd0, 8'h00, 4'd0);
    check_outs("ab_flushed", 1'b0, 1'b0, 4'h0, 8'h00, 1'b0, 1'b0, 3'd0);
    tick();
    check_outs("ab_quiet", 1'b0, 1'b0, 4'h0, 8'h00, 1'b0, 1'b0, 3'd0);

    // Asynchronous reset in the middle of HOLD x16 with one command queued.
    apply_stimulus(1'b1, 2'd3, 8'h00, 4'd15);
    tick();
    apply_stimulus(1'b1, 2'd1, 8'h09, 4'd0);
    tick();
    apply_stimulus(1'b0, 2'd0, 8'h00, 4'd0);
    tick();
    check_outs("hold_run", 1'b0, 1'b0, 4'h0, 8'h00, 1'b0, 1'b1, 3'd1);
    #2 reset_n = 1'b0;
    #1;
    check_outs("rst_async", 1'b0, 1'b0, 4'h0, 8'h00, 1'b0, 1'b0, 3'd0);
    check_output("rst_ready", 32'(cmd_ready), 32'd0);
    tick();
    tick();
    reset_n = 1'b1;
    apply_stimulus(1'b1, 2'd0, 8'h11, 4'd0);
    tick();
    apply_stimulus(1'b0, 2'd0, 8'h00, 4'd0);
    check_outs("rst_queued", 1'b0, 1'b0, 4'h0, 8'h00, 1'b0, 1'b1, 3'd1);
    tick();
    check_outs("rst_issue", 1'b1, 1'b0, 4'h0, 8'h11, 1'b1, 1'b1, 3'd0);
    tick();
    check_outs("rst_idle", 1'b0, 1'b0, 4'h0, 8'h00, 1'b0, 1'b0, 3'd0);

    // Maximum repeat: UP 0xF issued 16 times, single done on the last.
    apply_stimulus(1'b1, 2'd1, 8'h0F, 4'd15);
    tick();
    apply_stimulus(1'b0, 2'd0, 8'h00, 4'd0);
    ops_seen = 0; done_seen = 0; done_at = -1;
    for (int c = 1; c <= 20; c++) begin
      tick();
      if (up_dn && delta == 4'hF) ops_seen++;
      if (cmd_done) begin
        done_seen++;
        done_at = c;
      end
    end
    check_output("maxrep_ops", 32'(ops_seen), 32'd16);
    check_output("maxrep_dones", 32'(done_seen), 32'd1);
    check_output("maxrep_done_at", 32'(done_at), 32'd16);
    check_outs("maxrep_idle", 1'b0, 1'b0, 4'h0, 8'h00, 1'b0, 1'b0, 3'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
